// File: rtl/boot_loader.sv
// ============================================================================
// boot_loader : streams a counted, big-endian program image into instruction
//               memory one 32-bit word at a time, then releases the CPU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              runCPU,
    output logic              busy,
    output logic              err
);

    // 33 bits so that DEPTH itself is representable for any ADDR_W <= 32
    localparam logic [32:0] c_DEPTH = 33'd1 << ADDR_W;

    typedef enum logic [3:0] {
        S_CNT_HI = 4'd0,
        S_CNT_LO = 4'd1,
        S_B0     = 4'd2,
        S_B1     = 4'd3,
        S_B2     = 4'd4,
        S_B3     = 4'd5,
        S_WRITE  = 4'd6,
        S_RUN    = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cnt_hi;
    logic [15:0]        r_n;
    logic [ADDR_W-1:0]  r_idx;
    logic [31:0]        r_asm;

    logic               w_accept;
    logic [15:0]        w_n_new;
    logic               w_last;

    assign w_accept = rx_valid & rx_ready;
    assign w_n_new  = {r_cnt_hi, rx_data};
    // r_n >= 1 whenever WRITE is reachable, so N-1 never underflows here
    assign w_last   = (33'(r_idx) == (33'(r_n) - 33'd1));

    always_comb begin
        w_next     = r_state;
        rx_ready   = 1'b0;
        imem_we    = 1'b0;
        runCPU     = 1'b0;
        busy       = 1'b1;
        err        = 1'b0;
        imem_addr  = r_idx;
        imem_wdata = r_asm;
        case (r_state)
            S_CNT_HI: begin
                rx_ready = 1'b1;
                if (w_accept) w_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                rx_ready = 1'b1;
                if (w_accept) begin
                    if (w_n_new == 16'd0)                 w_next = S_RUN;
                    else if (33'(w_n_new) > c_DEPTH)      w_next = S_ERR;
                    else                                  w_next = S_B0;
                end
            end
            S_B0: begin
                rx_ready = 1'b1;
                if (w_accept) w_next = S_B1;
            end
            S_B1: begin
                rx_ready = 1'b1;
                if (w_accept) w_next = S_B2;
            end
            S_B2: begin
                rx_ready = 1'b1;
                if (w_accept) w_next = S_B3;
            end
            S_B3: begin
                rx_ready = 1'b1;
                if (w_accept) w_next = S_WRITE;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                w_next  = w_last ? S_RUN : S_B0;
            end
            S_RUN: begin
                runCPU = 1'b1;
                busy   = 1'b0;
            end
            S_ERR: begin
                err  = 1'b1;
                busy = 1'b0;
            end
            default: w_next = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_CNT_HI;
            r_cnt_hi <= 8'd0;
            r_n      <= 16'd0;
            r_idx    <= '0;
            r_asm    <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_CNT_HI: if (w_accept) r_cnt_hi <= rx_data;
                S_CNT_LO: begin
                    if (w_accept) begin
                        r_n   <= w_n_new;
                        r_idx <= '0;
                    end
                end
                S_B0, S_B1, S_B2, S_B3: begin
                    if (w_accept) r_asm <= {r_asm[23:0], rx_data};
                end
                // Holding the index on the last word keeps N == DEPTH from wrapping
                S_WRITE: if (!w_last) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// tb_boot_loader : directed, table-driven bench for boot_loader (ADDR_W=10 and
//                  a second ADDR_W=4 instance for the count-limit cases).
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_boot_loader;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tgt      = 1'b0;   // 0 drives the ADDR_W=10 instance, 1 the ADDR_W=4 one

    always #5 clk = ~clk;

    wire        valid_a = rx_valid & ~tgt;
    wire        valid_b = rx_valid & tgt;
    wire        rdy_a, we_a, run_a, busy_a, err_a;
    wire [9:0]  addr_a;
    wire [31:0] wd_a;
    wire        rdy_b, we_b, run_b, busy_b, err_b;
    wire [3:0]  addr_b;
    wire [31:0] wd_b;
    wire        rdy_s = tgt ? rdy_b : rdy_a;

    boot_loader #(.ADDR_W(10)) u_dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(valid_a),
        .rx_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .runCPU(run_a), .busy(busy_a), .err(err_a)
    );

    boot_loader #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(valid_b),
        .rx_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .runCPU(run_b), .busy(busy_b), .err(err_b)
    );

    int nvec = 0;
    int nfail = 0;

    // Write log per instance, sampled mid-cycle so each one-cycle pulse is seen once
    int          wr_a = 0, wr_b = 0, rdy_bad = 0;
    logic [31:0] wa_addr [64];
    logic [31:0] wa_data [64];
    logic [31:0] wb_addr [64];
    logic [31:0] wb_data [64];

    always @(negedge clk) begin
        if (we_a) begin
            if (wr_a < 64) begin
                wa_addr[wr_a] = 32'(addr_a);
                wa_data[wr_a] = wd_a;
            end
            wr_a++;
            if (rdy_a) rdy_bad++;
        end
        if (we_b) begin
            if (wr_b < 64) begin
                wb_addr[wr_b] = 32'(addr_b);
                wb_data[wr_b] = wd_b;
            end
            wr_b++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one byte and hold it until the selected instance takes it
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rdy_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_s) begin
            nvec++;
            nfail++;
            $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] word4(input int i);
        return 32'h9E3779B9 * 32'(i + 1);
    endfunction

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        run;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl [14];

    logic [7:0] stream [10];
    int base;
    int rb;

    initial begin : t_main
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'hC0, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'h1F, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 32'hC01F0005, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'hE0, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'hFC, 1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 10'd1, 32'h77E0FFFC, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 1'b0, 1'b0};

        stream[0] = 8'h00; stream[1] = 8'h02; stream[2] = 8'hC0; stream[3] = 8'h1F;
        stream[4] = 8'h00; stream[5] = 8'h05; stream[6] = 8'h77; stream[7] = 8'hE0;
        stream[8] = 8'hFF; stream[9] = 8'hFC;

        // Reset state
        tgt = 1'b0;
        do_reset();
        #1;
        check("rst rx_ready",   32'(rdy_a),  32'd1);
        check("rst imem_we",    32'(we_a),   32'd0);
        check("rst imem_addr",  32'(addr_a), 32'd0);
        check("rst imem_wdata", wd_a,        32'd0);
        check("rst runCPU",     32'(run_a),  32'd0);
        check("rst busy",       32'(busy_a), 32'd1);
        check("rst err",        32'(err_a),  32'd0);

        // Normal back-to-back load, cycle by cycle
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rx_valid = tbl[i].v;
            rx_data  = tbl[i].d;
            #1;
            check($sformatf("v%0d rx_ready", i), 32'(rdy_a),  32'(tbl[i].rdy));
            check($sformatf("v%0d imem_we", i),  32'(we_a),   32'(tbl[i].we));
            check($sformatf("v%0d runCPU", i),   32'(run_a),  32'(tbl[i].run));
            check($sformatf("v%0d busy", i),     32'(busy_a), 32'(tbl[i].busy));
            check($sformatf("v%0d err", i),      32'(err_a),  32'(tbl[i].err));
            if (tbl[i].we) begin
                check($sformatf("v%0d imem_addr", i),  32'(addr_a), 32'(tbl[i].addr));
                check($sformatf("v%0d imem_wdata", i), wd_a,        tbl[i].wd);
            end
        end
        rx_valid = 1'b0;

        // Same stream with 3 idle cycles between bytes
        do_reset();
        base = wr_a;
        rb   = rdy_bad;
        for (int i = 0; i < 10; i++) begin
            send(stream[i]);
            repeat (3) @(posedge clk);
        end
        repeat (3) @(negedge clk);
        check("gap write count", 32'(wr_a - base), 32'd2);
        check("gap w0 addr", wa_addr[base],     32'd0);
        check("gap w0 data", wa_data[base],     32'hC01F0005);
        check("gap w1 addr", wa_addr[base + 1], 32'd1);
        check("gap w1 data", wa_data[base + 1], 32'h77E0FFFC);
        check("gap ready during write", 32'(rdy_bad - rb), 32'd0);
        check("gap runCPU", 32'(run_a), 32'd1);

        // Empty load
        do_reset();
        base = wr_a;
        send(8'h00);
        send(8'h00);
        check("empty runCPU", 32'(run_a),  32'd1);
        check("empty busy",   32'(busy_a), 32'd0);
        check("empty err",    32'(err_a),  32'd0);
        repeat (2) @(negedge clk);
        check("empty no writes", 32'(wr_a - base), 32'd0);

        // Count limit on the ADDR_W=4 instance: 17 is too many, 16 fills memory
        tgt = 1'b1;
        do_reset();
        base = wr_b;
        send(8'h00);
        send(8'h11);
        repeat (2) @(negedge clk);
        check("over err",      32'(err_b), 32'd1);
        check("over runCPU",   32'(run_b), 32'd0);
        check("over rx_ready", 32'(rdy_b), 32'd0);
        check("over no writes", 32'(wr_b - base), 32'd0);

        do_reset();
        check("full err cleared", 32'(err_b), 32'd0);
        base = wr_b;
        send(8'h00);
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            for (int j = 3; j >= 0; j--) begin
                send(8'(word4(i) >> (8 * j)));
            end
        end
        repeat (3) @(negedge clk);
        check("full write count", 32'(wr_b - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full w%0d addr", i), wb_addr[base + i], 32'(i));
            check($sformatf("full w%0d data", i), wb_data[base + i], word4(i));
        end
        check("full runCPU", 32'(run_b), 32'd1);
        check("full err",    32'(err_b), 32'd0);

        // Reset mid-word, with a byte offered during the reset cycle
        tgt = 1'b0;
        do_reset();
        base = wr_a;
        send(8'h00);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("midrst rx_ready", 32'(rdy_a), 32'd1);
        check("midrst busy",     32'(busy_a), 32'd1);
        send(8'h00);
        send(8'h01);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        repeat (3) @(negedge clk);
        check("midrst write count", 32'(wr_a - base), 32'd1);
        check("midrst addr",   wa_addr[base], 32'd0);
        check("midrst data",   wa_data[base], 32'hDEADBEEF);
        check("midrst runCPU", 32'(run_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the instruction-memory word-address width; memory depth is DEPTH = 2^ADDR_W words.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  incoming program byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data is valid this cycle.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-008 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-009 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-010 SHALL have port runCPU  output  1  CPU run enable, driven into the CPU's runCPU input.
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port err  output  1  sticky load-error flag.

Function
REQ-013 SHALL accept a byte only on a rising edge where rx_valid and rx_ready are both 1; rx_data is ignored otherwise.
REQ-014 SHALL parse the stream as follows: a 16-bit big-endian word count N (2 bytes), then N 32-bit big-endian instruction words (4 bytes each, MSB first).
REQ-015 SHALL implement states CNT_HI, CNT_LO, B0, B1, B2, B3, WRITE, RUN, ERR.
REQ-016 SHALL drive rx_ready=1 in CNT_HI, CNT_LO and B0-B3, and rx_ready=0 in WRITE, RUN and ERR.
REQ-017 SHALL advance CNT_HI->CNT_LO->B0->B1->B2->B3->WRITE, one step per accepted byte, holding the current state while no byte is accepted.
REQ-018 SHALL, on accepting CNT_LO: go to RUN if N==0, go to ERR if N>DEPTH, and otherwise go to B0 with the word index cleared to 0.
REQ-019 SHALL, in WRITE, assert imem_we=1 for exactly one cycle, with imem_addr equal to the word index and imem_wdata equal to the assembled word.
REQ-020 SHALL, after WRITE, go to RUN if index==N-1; otherwise increment the index and go to B0.
REQ-021 SHALL hold imem_we=0 in every state other than WRITE; imem_addr and imem_wdata are don't-care while imem_we=0.
REQ-022 SHALL, for timing: when the last byte of a word is accepted at edge k, imem_we is high during cycle k..k+1, and runCPU is high from edge k+1 if that word is the last one.
REQ-023 SHALL hold runCPU=1 continuously in RUN, and RUN SHALL be left only by reset.
REQ-024 SHALL set err=1 in ERR, and ERR SHALL be left only by reset; runCPU stays 0 in ERR.
REQ-025 SHALL drive busy=1 in CNT_HI through WRITE and busy=0 in RUN and ERR.
REQ-026 SHALL treat N==DEPTH as legal, with the index reaching DEPTH-1 without wrap-around.
REQ-027 SHALL ignore any bytes offered in RUN or ERR, leaving them unconsumed because rx_ready=0.

Reset
REQ-028 SHALL, while reset=1 on a rising edge, enter CNT_HI and clear the index, the assembly register and N; reset SHALL take priority over a simultaneous byte acceptance.
REQ-029 SHALL produce these output values after reset: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, runCPU=0, busy=1, err=0.
REQ-030 SHALL, when reset is asserted mid-load or in RUN/ERR, abort immediately; the next byte accepted is interpreted as CNT_HI.

Verification
REQ-031 SHALL be verified with a normal load: bytes 00 02 C0 1F 00 05 77 E0 FF FC streamed back-to-back -> writes (addr 0, C01F0005) then (addr 1, 77E0FFFC), each exactly one cycle; runCPU rises one edge after the second write; busy falls at the same edge.
REQ-032 SHALL be verified with back-pressure gaps: the same stream with rx_valid low for 3 cycles between every byte -> identical writes, no extra writes, and rx_ready=0 during each WRITE cycle.
REQ-033 SHALL be verified with an empty load: bytes 00 00 -> runCPU=1 on the edge after the second byte, no imem_we pulse, err=0.
REQ-034 SHALL be verified with an oversize count: ADDR_W=4 and bytes 00 11 (N=17) -> err=1, runCPU=0, rx_ready=0 and no writes; then with bytes 00 10 (N=16) -> 16 writes at addresses 0..15, then runCPU=1.
REQ-035 SHALL be verified with reset mid-load: reset pulsed after the 3rd byte of word 0 -> no write occurs; a following stream 00 01 DE AD BE EF -> single write (addr 0, DEADBEEF), then runCPU=1.
